// File: rtl/gf180mcu_xnor_tree_pipe.sv
// rtl/gf180mcu_xnor_tree_pipe.sv - pipelined WIDTH-input XNOR/XOR reduction tree with valid/ready
// Optional saturating mismatch counter enabled by defining XNOR_TREE_PIPE_ERRCNT_EN.
module gf180mcu_xnor_tree_pipe #(
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic             POL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ZN
`ifdef XNOR_TREE_PIPE_ERRCNT_EN
  ,
  input  logic             EXP,
  input  logic             CNT_CLR,
  output logic [7:0]       ERR_CNT
`endif
);

  function automatic int lvl_w(input int k);
    int w;
    w = WIDTH;
    for (int i = 0; i < k; i++) w = (w + 2) / 3;
    return w;
  endfunction

  function automatic int lvl_off(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += lvl_w(i);
    return s;
  endfunction

  function automatic int num_levels();
    int w;
    int l;
    w = WIDTH;
    l = 0;
    while (w > 1) begin
      w = (w + 2) / 3;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int BUSW   = lvl_off(LEVELS + 1);

  // Every level's partial results live in one flat bus: slice k is the input of level k.
  logic [BUSW-1:0]   w_dat;
  logic [LEVELS:0]   w_vld;
  logic [LEVELS-1:0] w_pol;
  logic              w_stall;

  assign w_stall   = OUT_VALID & ~OUT_READY;
  assign IN_READY  = ~w_stall;
  assign w_dat[WIDTH-1:0] = A;
  assign w_vld[0]  = IN_VALID;
  assign w_pol[0]  = POL;
  assign OUT_VALID = w_vld[LEVELS];
  assign ZN        = w_dat[BUSW-1];

`ifdef XNOR_TREE_PIPE_ERRCNT_EN
  logic [LEVELS:0] w_exp;
  logic [7:0]      r_err_cnt;

  assign w_exp[0] = EXP;
  assign ERR_CNT  = r_err_cnt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_err_cnt <= 8'd0;
    end else if (CNT_CLR) begin
      r_err_cnt <= 8'd0;
    end else if (OUT_VALID && OUT_READY && (ZN != w_exp[LEVELS]) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW   = lvl_w(k);
    localparam int OW   = lvl_w(k + 1);
    localparam int PW   = 3 * OW;
    localparam int IO   = lvl_off(k);
    localparam int OO   = lvl_off(k + 1);
    localparam bit LAST = (k == LEVELS - 1);

    logic [PW-1:0] w_pad;
    logic [OW-1:0] w_red;
    logic [OW-1:0] r_data;
    logic          r_vld;

    assign w_pad = PW'(w_dat[IO +: IW]);

    always_comb begin
      w_red = '0;
      for (int j = 0; j < OW; j++) w_red[j] = ^w_pad[3*j +: 3];
    end

    // The last level folds polarity in so ZN comes straight off a flop.
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (!w_stall) begin
        r_data <= LAST ? (w_red ^ {OW{w_pol[k]}}) : w_red;
        r_vld  <= w_vld[k];
      end
    end

    assign w_dat[OO +: OW] = r_data;
    assign w_vld[k+1]      = r_vld;

    if (!LAST) begin : g_pol
      logic r_pol;
      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) r_pol <= 1'b0;
        else if (!w_stall) r_pol <= w_pol[k];
      end
      assign w_pol[k+1] = r_pol;
    end

`ifdef XNOR_TREE_PIPE_ERRCNT_EN
    logic r_exp;
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) r_exp <= 1'b0;
      else if (!w_stall) r_exp <= w_exp[k];
    end
    assign w_exp[k+1] = r_exp;
`endif
  end

endmodule
